blit_sequencer: RTL and testbench

Command queue and sequencer in front of the framebuffer `blitter`. The CPU side pushes fully-specified blit commands (clear, scroll, sprite) into a small FIFO without waiting for the blitter. The sequencer issues each command to the blitter using the blitter's enable/ready handshake and returns per-command completion and sprite collision results. It sits between the CHIP-8 CPU core and the `blitter` instance. It owns the blitter's `operation`, `src`, `srcHeight`, `destX`, `destY` and `enable` inputs.

---
 rtl/blit_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_blit_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_sequencer.sv
// Command FIFO and issue sequencer in front of the framebuffer blitter.
// Accepts packed blit commands from the CPU and issues them one at a time over
// the blitter's enable/ready handshake. It reports completion and collisions.
module blit_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [11:0] cmd_src,
  input  logic [3:0]  cmd_height,
  input  logic [6:0]  cmd_x,
  input  logic [5:0]  cmd_y,
  output logic        cmd_ready,
  input  logic        flush,
  output logic        busy,
  output logic [4:0]  level,
  output logic        done,
  output logic        done_collision,
  output logic        vf_collision,
  input  logic        vf_clear,
  output logic [2:0]  blit_operation,
  output logic [11:0] blit_src,
  output logic [3:0]  blit_height,
  output logic [6:0]  blit_x,
  output logic [5:0]  blit_y,
  output logic        blit_enable,
  input  logic        blit_ready,
  input  logic        blit_collision
);

  // Operation encoding shared with the blitter
  localparam logic [2:0] BLIT_OP_CLEAR        = 3'd0;
  localparam logic [2:0] BLIT_OP_SCROLL_DOWN  = 3'd1;
  localparam logic [2:0] BLIT_OP_SCROLL_RIGHT = 3'd2;
  localparam logic [2:0] BLIT_OP_SCROLL_LEFT  = 3'd3;
  localparam logic [2:0] BLIT_OP_SPRITE       = 3'd4;
  localparam logic [2:0] BLIT_OP_SPRITE_16    = 3'd5;

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_RELEASE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   w_head;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_done;
  logic          w_coll;

  logic          r_enable;
  logic          r_done;
  logic          r_done_coll;
  logic          r_vf;
  logic [2:0]    r_op;
  logic [11:0]   r_src;
  logic [3:0]    r_height;
  logic [6:0]    r_x;
  logic [5:0]    r_y;

  // Full/empty come from registered pointers only; the wrap bit separates them.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // A flush in the same cycle discards the push.
  assign w_push  = cmd_valid && !w_full && !flush;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  // Only sprite operations can report a collision.
  assign w_coll  = blit_collision &&
                   ((r_op == BLIT_OP_SPRITE) || (r_op == BLIT_OP_SPRITE_16));

  assign cmd_ready      = !w_full;
  assign level          = 5'(r_wptr - r_rptr);
  assign busy           = !w_empty || (r_state != S_IDLE);
  assign done           = r_done;
  assign done_collision = r_done_coll;
  assign vf_collision   = r_vf;
  assign blit_enable    = r_enable;
  assign blit_operation = r_op;
  assign blit_src       = r_src;
  assign blit_height    = r_height;
  assign blit_x         = r_x;
  assign blit_y         = r_y;

  // FIFO pointers; flush drops everything queued but leaves the in-flight blit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (flush)
        r_rptr <= r_wptr;
      else if (w_pop)
        r_rptr <= r_rptr + 1'b1;
    end
  end

  // FIFO storage, packed as {op, src, height, x, y}.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr[AW-1:0]] <= {cmd_op, cmd_src, cmd_height, cmd_x, cmd_y};
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_SYNC;
    else
      r_state <= w_next;
  end

  // Next-state logic with pop and completion strobes.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      // The blitter has no reset, so wait until it is idle before issuing.
      S_SYNC:    if (blit_ready) w_next = S_IDLE;
      S_IDLE:    if (!w_empty && !flush) begin
                   w_pop  = 1'b1;
                   w_next = S_ISSUE;
                 end
      S_ISSUE:   if (!blit_ready) w_next = S_RUN;
      S_RUN:     if (blit_ready) begin
                   w_done = 1'b1;
                   w_next = S_RELEASE;
                 end
      // One enable-low cycle lets the blitter return from DONE to WAITING.
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_SYNC;
    endcase
  end

  // Registered blitter command, enable and completion/collision reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable    <= 1'b0;
      r_done      <= 1'b0;
      r_done_coll <= 1'b0;
      r_vf        <= 1'b0;
      r_op        <= '0;
      r_src       <= '0;
      r_height    <= '0;
      r_x         <= '0;
      r_y         <= '0;
    end else begin
      r_done      <= w_done;
      r_done_coll <= w_done && w_coll;
      if (w_pop) begin
        {r_op, r_src, r_height, r_x, r_y} <= w_head;
        r_enable <= 1'b1;
      end else if (w_done) begin
        r_enable <= 1'b0;
      end
      // A collision arriving together with vf_clear still sets the flag.
      if (w_done && w_coll)
        r_vf <= 1'b1;
      else if (vf_clear)
        r_vf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blit_sequencer.sv
// Directed bench for blit_sequencer with a behavioural blitter model.
module tb_blit_sequencer;

  localparam logic [2:0] OP_CLEAR       = 3'd0;
  localparam logic [2:0] OP_SCROLL_DOWN = 3'd1;
  localparam logic [2:0] OP_SCROLL_LEFT = 3'd3;
  localparam logic [2:0] OP_SPRITE      = 3'd4;
  localparam logic [2:0] OP_SPRITE_16   = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [11:0] cmd_src = '0;
  logic [3:0]  cmd_height = '0;
  logic [6:0]  cmd_x = '0;
  logic [5:0]  cmd_y = '0;
  logic        cmd_ready;
  logic        flush = 1'b0;
  logic        busy;
  logic [4:0]  level;
  logic        done;
  logic        done_collision;
  logic        vf_collision;
  logic        vf_clear = 1'b0;
  logic [2:0]  blit_operation;
  logic [11:0] blit_src;
  logic [3:0]  blit_height;
  logic [6:0]  blit_x;
  logic [5:0]  blit_y;
  logic        blit_enable;
  logic        blit_ready;
  logic        blit_collision;
  logic [31:0] bfield;

  int n_chk = 0;
  int n_pass = 0;

  blit_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_src(cmd_src),
    .cmd_height(cmd_height), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_ready(cmd_ready), .flush(flush), .busy(busy), .level(level),
    .done(done), .done_collision(done_collision),
    .vf_collision(vf_collision), .vf_clear(vf_clear),
    .blit_operation(blit_operation), .blit_src(blit_src),
    .blit_height(blit_height), .blit_x(blit_x), .blit_y(blit_y),
    .blit_enable(blit_enable), .blit_ready(blit_ready),
    .blit_collision(blit_collision)
  );

  always #5 clk = ~clk;

  assign bfield = {blit_operation, blit_src, blit_height, blit_x, blit_y};

  // Blitter model: WAITING(0) -> running(1) -> DONE(2) -> WAITING once enable drops.
  logic [1:0] m_st = 2'd0;
  int         m_cnt = 0;
  int         m_len = 4;
  logic       m_coll = 1'b0;
  logic       m_collision = 1'b0;
  logic       m_stall = 1'b0;

  assign blit_ready     = (m_st != 2'd1) && !m_stall;
  assign blit_collision = m_collision;

  always @(posedge clk) begin
    case (m_st)
      2'd0: if (blit_enable) begin
              m_st  <= 2'd1;
              m_cnt <= m_len;
            end
      2'd1: if (m_cnt <= 1) begin
              m_st        <= 2'd2;
              m_collision <= m_coll;
            end else begin
              m_cnt <= m_cnt - 1;
            end
      default: if (!blit_enable) m_st <= 2'd0;
    endcase
  end

  // Monitor: log each issued command, the enable-low gap before it and done pulses.
  logic        prev_en = 1'b0;
  int          low_cnt = 0;
  int          n_done = 0;
  int          bad_issue = 0;
  logic [31:0] rec_q[$];
  int          gap_q[$];
  logic        dc_q[$];

  always @(negedge clk) begin
    if (blit_enable && !prev_en) begin
      rec_q.push_back(bfield);
      gap_q.push_back(low_cnt);
      if (m_st == 2'd1) bad_issue <= bad_issue + 1;
    end
    low_cnt <= blit_enable ? 0 : low_cnt + 1;
    prev_en <= blit_enable;
    if (done) begin
      n_done <= n_done + 1;
      dc_q.push_back(done_collision);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] c);
    {cmd_op, cmd_src, cmd_height, cmd_x, cmd_y} = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n);
    for (int i = 0; i < 300 && n_done < n; i++) @(negedge clk);
    chk(tag, n_done, n);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    chk(tag, {31'd0, busy}, 0);
  endtask

  logic [31:0] vec [4];
  logic [31:0] c_a;
  int          base;
  int          d0;
  int          en_hi;
  int          lvl_fill;
  int          rdy_fill;

  initial begin
    vec[0] = {OP_SPRITE,      12'h300, 4'd5,  7'd10, 6'd20};
    vec[1] = {OP_SCROLL_DOWN, 12'h000, 4'd0,  7'd0,  6'd4};
    vec[2] = {OP_SPRITE_16,   12'hABC, 4'd15, 7'd63, 6'd31};
    vec[3] = {OP_SCROLL_LEFT, 12'h001, 4'd1,  7'd127, 6'd63};

    // Reset while the blitter still reports not-ready.
    @(negedge clk);
    m_stall = 1'b1;
    cycles(3);
    chk("rst_enable", {31'd0, blit_enable}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_done_coll", {31'd0, done_collision}, 0);
    chk("rst_vf", {31'd0, vf_collision}, 0);
    chk("rst_level", {27'd0, level}, 0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 1);
    chk("rst_fields", bfield, 0);
    reset = 1'b0;
    c_a = {OP_CLEAR, 12'h123, 4'd0, 7'd0, 6'd0};
    push(c_a);
    chk("sync_level", {27'd0, level}, 1);
    en_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (blit_enable) en_hi++;
    end
    chk("sync_hold_enable", en_hi, 0);
    m_stall = 1'b0;
    cycles(2);
    chk("sync_release_enable", {31'd0, blit_enable}, 1);
    chk("sync_release_cmd", bfield, c_a);
    wait_done("sync_done", 1);
    wait_idle("sync_idle");

    // Fill the FIFO behind a long blit, then drain back-to-back.
    base = rec_q.size();
    d0 = n_done;
    m_len = 40;
    push({OP_SCROLL_DOWN, 12'h000, 4'd0, 7'd0, 6'd2});
    cycles(3);
    m_len = 3;
    for (int i = 0; i < 4; i++) push(vec[i]);
    lvl_fill = level;
    rdy_fill = cmd_ready;
    chk("fill_level", lvl_fill, 4);
    chk("fill_cmd_ready", rdy_fill, 0);
    push({OP_CLEAR, 12'hFFF, 4'd7, 7'd7, 6'd7});
    chk("full_push_ignored", {27'd0, level}, 4);
    wait_done("b2b_done", d0 + 5);
    wait_idle("b2b_idle");
    chk("b2b_issue_count", rec_q.size(), base + 5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_cmd%0d", i), rec_q[base + 1 + i], vec[i]);
      chk($sformatf("b2b_gap%0d", i), gap_q[base + 1 + i], 2);
    end

    // Sprite collision is reported; non-sprite collision is masked.
    m_coll = 1'b1;
    m_len = 4;
    d0 = n_done;
    push({OP_SPRITE, 12'h200, 4'd8, 7'd5, 6'd3});
    wait_done("spr_done", d0 + 1);
    chk("spr_done_coll", {31'd0, dc_q[dc_q.size() - 1]}, 1);
    chk("spr_vf", {31'd0, vf_collision}, 1);
    chk("spr_cmd", rec_q[rec_q.size() - 1], {OP_SPRITE, 12'h200, 4'd8, 7'd5, 6'd3});
    push({OP_SCROLL_LEFT, 12'h000, 4'd0, 7'd0, 6'd0});
    wait_done("scl_done", d0 + 2);
    chk("scl_done_coll", {31'd0, dc_q[dc_q.size() - 1]}, 0);
    chk("scl_vf_kept", {31'd0, vf_collision}, 1);
    vf_clear = 1'b1;
    @(negedge clk);
    vf_clear = 1'b0;
    chk("vf_cleared", {31'd0, vf_collision}, 0);
    wait_idle("coll_idle");

    // Flush while the first blit runs with three queued.
    m_coll = 1'b0;
    m_len = 30;
    d0 = n_done;
    base = rec_q.size();
    for (int i = 0; i < 4; i++) push(vec[i]);
    chk("flush_pre_level", {27'd0, level}, 3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_level", {27'd0, level}, 0);
    chk("flush_busy", {31'd0, busy}, 1);
    wait_done("flush_done", d0 + 1);
    wait_idle("flush_idle");
    cycles(10);
    chk("flush_single_done", n_done, d0 + 1);
    chk("flush_issue_count", rec_q.size(), base + 1);
    chk("flush_cmd", rec_q[base], vec[0]);

    // vf_clear held across a colliding sprite completion: set wins.
    m_coll = 1'b1;
    m_len = 5;
    vf_clear = 1'b1;
    push({OP_SPRITE_16, 12'h050, 4'd2, 7'd1, 6'd1});
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    chk("vfset_done", {31'd0, done}, 1);
    chk("vfset_wins", {31'd0, vf_collision}, 1);
    vf_clear = 1'b0;
    wait_idle("vfset_idle");

    // Push together with flush is discarded.
    base = rec_q.size();
    {cmd_op, cmd_src, cmd_height, cmd_x, cmd_y} = vec[0];
    cmd_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    flush = 1'b0;
    chk("pushflush_level", {27'd0, level}, 0);
    cycles(5);
    chk("pushflush_busy", {31'd0, busy}, 0);
    chk("pushflush_no_issue", rec_q.size(), base);

    // Reset in RUN: enable drops, done lost, nothing issued into the busy blitter.
    m_coll = 1'b0;
    m_len = 30;
    d0 = n_done;
    push({OP_SPRITE, 12'h111, 4'd3, 7'd9, 6'd9});
    for (int i = 0; i < 20 && m_st != 2'd1; i++) @(negedge clk);
    chk("rr_model_busy", {30'd0, m_st}, 1);
    cycles(2);
    reset = 1'b1;
    @(negedge clk);
    chk("rr_enable", {31'd0, blit_enable}, 0);
    chk("rr_level", {27'd0, level}, 0);
    chk("rr_busy", {31'd0, busy}, 1);
    reset = 1'b0;
    c_a = {OP_CLEAR, 12'h0AB, 4'd0, 7'd0, 6'd0};
    push(c_a);
    for (int i = 0; i < 100 && m_st == 2'd1; i++) @(negedge clk);
    cycles(1);
    chk("rr_no_done", n_done, d0);
    wait_done("rr_next_done", d0 + 1);
    chk("rr_next_cmd", rec_q[rec_q.size() - 1], c_a);
    wait_idle("rr_idle");
    chk("no_issue_into_busy", bad_issue, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
